test_pattern_gen: RTL and testbench

- Per-pixel video test pattern source for the VGA display path.
- Takes the column/row position from the VGA sync counter block and a 4-bit pattern select.
- Produces registered red, green and blue video words, one clock after the position is presented.
- Outside the active area the output is forced to black, so the block can drive the DAC/pins directly.

---
 rtl/vga_pkg.sv | 14 +
 rtl/color_bar_index.sv | 23 ++
 rtl/test_pattern_gen.sv | 91 +++++++++
 tb/tb_test_pattern_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: count width used by the sync counter and pattern select codes.
package vga_pkg;

  localparam int unsigned COUNT_W = 10;

  localparam logic [3:0] PAT_BLACK   = 4'd0;
  localparam logic [3:0] PAT_RED     = 4'd1;
  localparam logic [3:0] PAT_GREEN   = 4'd2;
  localparam logic [3:0] PAT_BLUE    = 4'd3;
  localparam logic [3:0] PAT_CHECKER = 4'd4;
  localparam logic [3:0] PAT_BARS    = 4'd5;
  localparam logic [3:0] PAT_BORDER  = 4'd6;

endpackage

// File: rtl/color_bar_index.sv
// Maps a column to one of eight equal-width colour bars using a comparator chain.
module color_bar_index
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE_COLS = 640
) (
  input  logic [COUNT_W-1:0] i_Col,
  output logic [2:0]         o_Index
);

  localparam int BAR_W = int'(ACTIVE_COLS / 8);

  // Thresholds are monotonic, so the last one passed is the bar index; saturates at 7.
  always_comb begin
    o_Index = 3'd0;
    for (int j = 1; j < 8; j++) begin
      if (int'(i_Col) >= j * BAR_W) begin
        o_Index = 3'(j);
      end
    end
  end

endmodule

// File: rtl/test_pattern_gen.sv
// Per-pixel test pattern source with registered RGB output, black outside the active area.
module test_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned ACTIVE_COLS = 640,
  parameter int unsigned ACTIVE_ROWS = 480,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned BORDER      = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [3:0]             i_Pattern,
  input  logic [COUNT_W-1:0]     i_Col_Count,
  input  logic [COUNT_W-1:0]     i_Row_Count,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam logic [VIDEO_WIDTH-1:0] FULL = {VIDEO_WIDTH{1'b1}};
  localparam int COL_HI = int'(ACTIVE_COLS) - int'(BORDER);
  localparam int ROW_HI = int'(ACTIVE_ROWS) - int'(BORDER);

  logic [VIDEO_WIDTH-1:0] r_Red, r_Grn, r_Blu;
  logic [VIDEO_WIDTH-1:0] w_Red, w_Grn, w_Blu;
  logic [2:0]             w_Bar;
  logic                   w_Active;
  logic                   w_Check;
  logic                   w_Border;

  color_bar_index #(
    .ACTIVE_COLS(ACTIVE_COLS)
  ) u_bar_index (
    .i_Col  (i_Col_Count),
    .o_Index(w_Bar)
  );

  assign w_Active = (int'(i_Col_Count) < int'(ACTIVE_COLS)) &&
                    (int'(i_Row_Count) < int'(ACTIVE_ROWS));
  assign w_Check  = i_Col_Count[CHECK_LOG2] ^ i_Row_Count[CHECK_LOG2];
  // Signed compare so an oversized border turns the whole area white.
  assign w_Border = (int'(i_Col_Count) < int'(BORDER)) || (int'(i_Col_Count) >= COL_HI) ||
                    (int'(i_Row_Count) < int'(BORDER)) || (int'(i_Row_Count) >= ROW_HI);

  always_comb begin
    w_Red = '0;
    w_Grn = '0;
    w_Blu = '0;
    if (w_Active) begin
      case (i_Pattern)
        PAT_RED:   w_Red = FULL;
        PAT_GREEN: w_Grn = FULL;
        PAT_BLUE:  w_Blu = FULL;
        PAT_CHECKER: begin
          w_Red = w_Check ? FULL : '0;
          w_Grn = w_Check ? FULL : '0;
          w_Blu = w_Check ? FULL : '0;
        end
        PAT_BARS: begin
          w_Red = w_Bar[2] ? FULL : '0;
          w_Grn = w_Bar[1] ? FULL : '0;
          w_Blu = w_Bar[0] ? FULL : '0;
        end
        PAT_BORDER: begin
          w_Red = w_Border ? FULL : '0;
          w_Grn = w_Border ? FULL : '0;
          w_Blu = w_Border ? FULL : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Red <= '0;
      r_Grn <= '0;
      r_Blu <= '0;
    end else begin
      r_Red <= w_Red;
      r_Grn <= w_Grn;
      r_Blu <= w_Blu;
    end
  end

  assign o_Red_Video = r_Red;
  assign o_Grn_Video = r_Grn;
  assign o_Blu_Video = r_Blu;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen with an 8x4 active area inside a 10x6 frame.
module tb_test_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pattern = 4'd0;
  logic [9:0] col = '0;
  logic [9:0] row = '0;
  logic [2:0] red, grn, blu;

  int total = 0;
  int bad = 0;

  test_pattern_gen #(
    .VIDEO_WIDTH(3),
    .ACTIVE_COLS(8),
    .ACTIVE_ROWS(4),
    .CHECK_LOG2 (1),
    .BORDER     (1)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .i_Pattern  (pattern),
    .i_Col_Count(col),
    .i_Row_Count(row),
    .o_Red_Video(red),
    .o_Grn_Video(grn),
    .o_Blu_Video(blu)
  );

  always #5 clk = ~clk;

  // Present one pixel, then wait for the edge that registers it plus a settle delay.
  task automatic pixel(input logic [3:0] p, input int c, input int r);
    pattern = p;
    col = 10'(c);
    row = 10'(r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pattern = 4'd1;
    col = '0;
    row = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({red, grn, blu} !== 9'b000_000_000) begin
      bad++;
      $display("FAIL reset_hold: got %b want 000000000", {red, grn, blu});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({red, grn, blu} !== 9'b111_000_000) begin
      bad++;
      $display("FAIL reset_release: got %b want 111000000", {red, grn, blu});
    end
  endtask

  task automatic test_async_reset();
    pixel(4'd1, 2, 1);
    total++;
    if ({red, grn, blu} !== 9'b111_000_000) begin
      bad++;
      $display("FAIL pre_async_red: got %b want 111000000", {red, grn, blu});
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({red, grn, blu} !== 9'b000_000_000) begin
      bad++;
      $display("FAIL async_clear: got %b want 000000000", {red, grn, blu});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_solid_blue();
    logic [8:0] exp;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 10; c++) begin
        pixel(4'd3, c, r);
        exp = (c < 8 && r < 4) ? 9'b000_000_111 : 9'b000_000_000;
        total++;
        if ({red, grn, blu} !== exp) begin
          bad++;
          $display("FAIL blue_frame c=%0d r=%0d: got %b want %b", c, r, {red, grn, blu}, exp);
        end
      end
    end
  endtask

  task automatic test_bars();
    logic [8:0] exp [8];
    exp = '{9'b000_000_000, 9'b000_000_111, 9'b000_111_000, 9'b000_111_111,
            9'b111_000_000, 9'b111_000_111, 9'b111_111_000, 9'b111_111_111};
    for (int c = 0; c < 8; c++) begin
      pixel(4'd5, c, 0);
      total++;
      if ({red, grn, blu} !== exp[c]) begin
        bad++;
        $display("FAIL bars c=%0d: got %b want %b", c, {red, grn, blu}, exp[c]);
      end
    end
  endtask

  task automatic test_checker();
    int         cs [4];
    int         rs [4];
    logic [8:0] exp [4];
    cs  = '{0, 2, 0, 2};
    rs  = '{0, 0, 2, 2};
    exp = '{9'h000, 9'h1FF, 9'h1FF, 9'h000};
    for (int i = 0; i < 4; i++) begin
      pixel(4'd4, cs[i], rs[i]);
      total++;
      if ({red, grn, blu} !== exp[i]) begin
        bad++;
        $display("FAIL checker (%0d,%0d): got %b want %b", cs[i], rs[i], {red, grn, blu}, exp[i]);
      end
    end
  endtask

  task automatic test_border();
    int         cs [6];
    int         rs [6];
    logic [8:0] exp [6];
    cs  = '{0, 7, 3, 0, 3, 5};
    rs  = '{0, 3, 0, 2, 1, 2};
    exp = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 9'h000};
    for (int i = 0; i < 6; i++) begin
      pixel(4'd6, cs[i], rs[i]);
      total++;
      if ({red, grn, blu} !== exp[i]) begin
        bad++;
        $display("FAIL border (%0d,%0d): got %b want %b", cs[i], rs[i], {red, grn, blu}, exp[i]);
      end
    end
  endtask

  task automatic test_solids_and_reserved();
    logic [8:0] exp [3];
    exp = '{9'b111_000_000, 9'b000_111_000, 9'b000_000_000};
    pixel(4'd1, 4, 2);
    total++;
    if ({red, grn, blu} !== exp[0]) begin
      bad++;
      $display("FAIL solid_red: got %b want %b", {red, grn, blu}, exp[0]);
    end
    pixel(4'd2, 6, 3);
    total++;
    if ({red, grn, blu} !== exp[1]) begin
      bad++;
      $display("FAIL solid_green: got %b want %b", {red, grn, blu}, exp[1]);
    end
    for (int p = 7; p < 16; p++) begin
      pixel(4'(p), 2, 1);
      total++;
      if ({red, grn, blu} !== exp[2]) begin
        bad++;
        $display("FAIL reserved p=%0d: got %b want %b", p, {red, grn, blu}, exp[2]);
      end
    end
    pixel(4'd0, 2, 1);
    total++;
    if ({red, grn, blu} !== exp[2]) begin
      bad++;
      $display("FAIL black: got %b want %b", {red, grn, blu}, exp[2]);
    end
  endtask

  task automatic test_pattern_switch();
    logic [8:0] exp;
    for (int c = 0; c < 8; c++) begin
      pixel((c <= 4) ? 4'd9 : 4'd2, c, 1);
      exp = (c <= 4) ? 9'b000_000_000 : 9'b000_111_000;
      total++;
      if ({red, grn, blu} !== exp) begin
        bad++;
        $display("FAIL switch c=%0d: got %b want %b", c, {red, grn, blu}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_solid_blue();
    test_bars();
    test_checker();
    test_border();
    test_solids_and_reserved();
    test_pattern_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
